data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the LSU data-memory handshake. It serves NUM_CHANNELS independent LSU read/write channels from one internal single-port RAM.
- A round-robin arbiter grants one request at a time. The granted request completes after a fixed access latency, and the responder pulses the channel's ready for one cycle, with read data for loads.
- Sits between the per-thread LSUs and data memory as the simulation/FPGA data-memory model.

Parameters:
- NUM_CHANNELS, 4, number of LSU channels served.
- ADDR_BITS, 16, address width per channel.
- MEM_DATA_WIDTH, 8, data word width.
- DEPTH, 256, RAM words (power of two); index = address[log2(DEPTH)-1:0].
- LATENCY, 2, access cycles from grant to ready pulse (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_read_valid  in  NUM_CHANNELS  per-channel load request.
- mem_read_address  in  NUM_CHANNELS*ADDR_BITS  packed load addresses; channel i at [i*ADDR_BITS +: ADDR_BITS].
- mem_read_ready  out  NUM_CHANNELS  one-cycle load-complete pulse.
- mem_read_data  out  NUM_CHANNELS*MEM_DATA_WIDTH  packed load data, valid while ready is high, then held.
- mem_write_valid  in  NUM_CHANNELS  per-channel store request.
- mem_write_address  in  NUM_CHANNELS*ADDR_BITS  packed store addresses.
- mem_write_data  in  NUM_CHANNELS*MEM_DATA_WIDTH  packed store data.
- mem_write_ready  out  NUM_CHANNELS  one-cycle store-complete pulse.
- busy  out  1  high while in ACCESS or RESPOND.

Behaviour:
- Reset values:
  - All ready bits, busy and mem_read_data are 0.
  - FSM goes to IDLE and the round-robin pointer goes to NUM_CHANNELS-1, so channel 0 wins first.
  - All release flags are cleared.
  - RAM contents are not cleared by reset.
- Eligibility: channel i is eligible when (read_valid[i] or write_valid[i]) and release[i]==0.
- FSM states:
  - IDLE:
    - If any channel is eligible, grant the first eligible channel searching from pointer+1 upward with wrap.
    - Latch the channel index, op, address and write data.
    - pointer <= granted index; cnt <= LATENCY-1; go to ACCESS.
    - Within one channel, write has priority over read when both valids are high.
  - ACCESS:
    - While cnt!=0: cnt decrements.
    - At the edge where cnt==0, perform the op:
      - write: RAM[idx] <= latched data.
      - read: mem_read_data slice <= RAM[idx].
    - Set that channel's read_ready or write_ready to 1 and go to RESPOND.
  - RESPOND:
    - Ready deasserts at the next edge.
    - release[ch] <= 1; go to IDLE.
- Latency:
  - Valid sampled high at edge E0 in IDLE means ready is high during the cycle after edge E0+LATENCY, for exactly one cycle.
  - Next grant is no earlier than edge E0+LATENCY+2.
  - Peak throughput is one access per LATENCY+2 cycles.
- Release rule:
  - release[i] clears on any edge where both read_valid[i] and write_valid[i] are low.
  - While release[i] is set, the channel cannot be re-granted. This prevents double-serving an LSU that drops valid only after sampling ready.
- Captured request: address and data are latched at grant. Valid falling or address changing afterwards does not abort the access; the ready pulse still occurs.
- Address: high bits above log2(DEPTH) are ignored, so addresses wrap modulo DEPTH.
- mem_read_data per channel holds its last value until that channel's next load completes. Stores do not alter mem_read_data.
- Ready bits are mutually exclusive: at most one ready bit (read or write, any channel) is high per cycle.
- Reset mid-operation:
  - Any access not yet at its cnt==0 edge is discarded, so no RAM write occurs.
  - Readies drop at the reset edge.

Test Plan:
- Single store then load, ch0, LATENCY=2:
  - Stimulus: write_valid[0]=1, addr 0x0010, data 0xA5; after its ready, read_valid[0]=1, addr 0x0010.
  - Required: write_ready[0] pulses 1 cycle at E0+2; read_ready[0] pulses 1 cycle with read data slice 0 = 0xA5.
- Round robin:
  - Stimulus: all 4 channels raise read_valid at the same edge, addresses preloaded with 0x11/0x22/0x33/0x44.
  - Required: ready order ch0,ch1,ch2,ch3, each ready 4 cycles apart (LATENCY+2), each with its own data.
- Held valid:
  - Stimulus: ch1 keeps read_valid=1 for 3 cycles after its ready pulse.
  - Required: no second ready on ch1 until valid drops low then rises again.
- Address wrap:
  - Stimulus: store 0x3C to addr 0x0105, then load addr 0x0005.
  - Required: load returns 0x3C.
- Same-channel read and write both high:
  - Stimulus: ch2 read_valid=1 and write_valid=1 simultaneously.
  - Required: write is served first (write_ready[2]); read is not served until both valids drop and read is reasserted.
- Reset mid-access:
  - Stimulus: assert reset 1 cycle after granting a store of 0xFF to addr 0x20 (addr 0x20 previously 0x00).
  - Required: no ready pulse, busy=0; a subsequent load of 0x20 returns 0x00.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the LSU handshake.
// Serves several independent load/store channels from one single-port RAM.
// A round-robin arbiter picks one request and latches it. The responder then
// counts out a fixed access latency and pulses that channel's ready for one cycle.
module data_mem_responder #(
  parameter int NUM_CHANNELS   = 4,
  parameter int ADDR_BITS      = 16,
  parameter int MEM_DATA_WIDTH = 8,
  parameter int DEPTH          = 256,
  parameter int LATENCY        = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0]      mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS*MEM_DATA_WIDTH-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0]      mem_write_address,
  input  logic [NUM_CHANNELS*MEM_DATA_WIDTH-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  output logic                                   busy
);

  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_BITS  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_t;

  state_t state, state_next;

  logic [CH_BITS-1:0]        ptr;
  logic [CH_BITS-1:0]        grant_ch;
  logic [CH_BITS-1:0]        cand;
  logic                      grant_found;
  logic [NUM_CHANNELS-1:0]   release_flags;
  logic [NUM_CHANNELS-1:0]   eligible;
  logic                      do_grant;
  logic                      do_access;

  logic [CH_BITS-1:0]        lat_ch;
  logic                      lat_write;
  logic [IDX_BITS-1:0]       lat_idx;
  logic [MEM_DATA_WIDTH-1:0] lat_wdata;
  logic [CNT_BITS-1:0]       cnt;

  logic [MEM_DATA_WIDTH-1:0] ram [DEPTH];

  // A channel competes only once the previous response has been acknowledged by dropping valid.
  assign eligible = (mem_read_valid | mem_write_valid) & ~release_flags;
  assign busy     = (state != IDLE);

  // Round-robin search: first eligible channel after the last one granted, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      cand = CH_BITS'((int'(ptr) + k) % NUM_CHANNELS);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode: grant in IDLE, perform the access when the latency count expires.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          do_grant   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          do_access  = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency counter, ready pulses, load data and release bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr             <= CH_BITS'(NUM_CHANNELS - 1);
      cnt             <= '0;
      lat_ch          <= '0;
      lat_write       <= 1'b0;
      lat_idx         <= '0;
      lat_wdata       <= '0;
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      mem_read_data   <= '0;
      release_flags   <= '0;
    end else begin
      mem_read_ready  <= '0;
      mem_write_ready <= '0;

      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (!mem_read_valid[i] && !mem_write_valid[i]) release_flags[i] <= 1'b0;
      end

      if (do_grant) begin
        ptr       <= grant_ch;
        cnt       <= CNT_BITS'(LATENCY - 1);
        lat_ch    <= grant_ch;
        lat_write <= mem_write_valid[grant_ch];
        if (mem_write_valid[grant_ch]) begin
          lat_idx   <= mem_write_address[grant_ch*ADDR_BITS +: IDX_BITS];
          lat_wdata <= mem_write_data[grant_ch*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
        end else begin
          lat_idx   <= mem_read_address[grant_ch*ADDR_BITS +: IDX_BITS];
          lat_wdata <= '0;
        end
      end

      if (state == ACCESS && cnt != '0) cnt <= cnt - 1'b1;

      if (do_access) begin
        if (lat_write) begin
          mem_write_ready[lat_ch] <= 1'b1;
        end else begin
          mem_read_ready[lat_ch] <= 1'b1;
          mem_read_data[lat_ch*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= ram[lat_idx];
        end
      end

      if (state == RESPOND) release_flags[lat_ch] <= 1'b1;
    end
  end

  // RAM write port; contents survive reset, and a reset edge cancels a pending store.
  always_ff @(posedge clk) begin
    if (!reset && do_access && lat_write) ram[lat_idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (4 channels, LATENCY=2).
module tb_data_mem_responder;

  localparam int NC = 4;
  localparam int AB = 16;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    mem_read_valid;
  logic [NC*AB-1:0] mem_read_address;
  logic [NC-1:0]    mem_read_ready;
  logic [NC*DW-1:0] mem_read_data;
  logic [NC-1:0]    mem_write_valid;
  logic [NC*AB-1:0] mem_write_address;
  logic [NC*DW-1:0] mem_write_data;
  logic [NC-1:0]    mem_write_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  int         cyc_count;
  logic [7:0] rdata;
  int         seen_cycle [NC];
  logic [7:0] seen_data  [NC];
  logic [7:0] exp_rr     [NC];
  bit         multi_ready;
  bit         got;
  int         extra_ready;
  int         bad_cycles;

  data_mem_responder #(
    .NUM_CHANNELS(NC), .ADDR_BITS(AB), .MEM_DATA_WIDTH(DW), .DEPTH(256), .LATENCY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_read_valid  = '0;
    mem_write_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One complete transaction on one channel; returns negedges from drive to ready and load data.
  task automatic apply_stimulus(input int ch, input bit is_write, input logic [15:0] addr,
                                input logic [7:0] wdata, output int cycles, output logic [7:0] data);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    @(negedge clk);
    if (is_write) begin
      mem_write_address[ch*AB +: AB] = addr;
      mem_write_data[ch*DW +: DW]    = wdata;
      mem_write_valid[ch]            = 1'b1;
    end else begin
      mem_read_address[ch*AB +: AB] = addr;
      mem_read_valid[ch]            = 1'b1;
    end
    while (!seen && cycles < 30) begin
      @(negedge clk);
      cycles++;
      seen = is_write ? mem_write_ready[ch] : mem_read_ready[ch];
    end
    if (!seen) check_output("ready_timeout", 32'd0, 32'd1);
    data = mem_read_data[ch*DW +: DW];
    mem_read_valid[ch]  = 1'b0;
    mem_write_valid[ch] = 1'b0;
    @(negedge clk);
    check_output("pulse_width", {31'd0, (is_write ? mem_write_ready[ch] : mem_read_ready[ch])}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset             = 1'b1;
    mem_read_valid    = '0;
    mem_write_valid   = '0;
    mem_read_address  = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    exp_rr[0] = 8'h11; exp_rr[1] = 8'h22; exp_rr[2] = 8'h33; exp_rr[3] = 8'h44;

    repeat (3) @(negedge clk);
    check_output("rst_read_ready", {28'd0, mem_read_ready}, 32'd0);
    check_output("rst_write_ready", {28'd0, mem_write_ready}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_read_data", mem_read_data, 32'd0);
    reset = 1'b0;

    // Store then load on channel 0.
    apply_stimulus(0, 1'b1, 16'h0010, 8'hA5, cyc_count, rdata);
    check_output("store_latency", cyc_count, 32'd3);
    apply_stimulus(0, 1'b0, 16'h0010, 8'h00, cyc_count, rdata);
    check_output("load_latency", cyc_count, 32'd3);
    check_output("load_data", {24'd0, rdata}, 32'h0000_00A5);

    // Preload for the round-robin test, then reset so channel 0 wins first.
    for (int i = 0; i < NC; i++)
      apply_stimulus(0, 1'b1, 16'(16'h0040 + i), exp_rr[i], cyc_count, rdata);
    apply_reset();
    @(negedge clk);
    check_output("rst2_read_data", mem_read_data, 32'd0);
    check_output("rst2_busy", {31'd0, busy}, 32'd0);

    // All four channels request in the same cycle.
    for (int i = 0; i < NC; i++) begin
      mem_read_address[i*AB +: AB] = 16'(16'h0040 + i);
      seen_cycle[i] = 0;
      seen_data[i]  = 8'h00;
    end
    multi_ready    = 1'b0;
    mem_read_valid = 4'hF;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check_output("rr_busy", {31'd0, busy}, 32'd1);
      if ($countones({mem_read_ready, mem_write_ready}) > 1) multi_ready = 1'b1;
      for (int i = 0; i < NC; i++) begin
        if (mem_read_ready[i]) begin
          seen_cycle[i]     = cyc;
          seen_data[i]      = mem_read_data[i*DW +: DW];
          mem_read_valid[i] = 1'b0;
        end
      end
    end
    check_output("rr_onehot", {31'd0, multi_ready}, 32'd0);
    for (int i = 0; i < NC; i++) begin
      check_output($sformatf("rr_cycle_ch%0d", i), seen_cycle[i], 32'(3 + 4 * i));
      check_output($sformatf("rr_data_ch%0d", i), {24'd0, seen_data[i]}, {24'd0, exp_rr[i]});
    end

    // Channel 1 keeps valid high after its ready; no re-serve until valid drops.
    @(negedge clk);
    mem_read_address[1*AB +: AB] = 16'h0041;
    mem_read_valid[1] = 1'b1;
    got = 1'b0;
    for (int cyc = 0; cyc < 30 && !got; cyc++) begin
      @(negedge clk);
      got = mem_read_ready[1];
    end
    check_output("hold_first_ready", {31'd0, got}, 32'd1);
    extra_ready = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (mem_read_ready[1]) extra_ready++;
      if (cyc == 3) mem_read_valid[1] = 1'b0;
    end
    check_output("hold_no_reserve", extra_ready, 32'd0);
    apply_stimulus(1, 1'b0, 16'h0041, 8'h00, cyc_count, rdata);
    check_output("hold_reissue_data", {24'd0, rdata}, 32'h0000_0022);

    // Address wraps modulo DEPTH.
    apply_stimulus(3, 1'b1, 16'h0105, 8'h3C, cyc_count, rdata);
    apply_stimulus(3, 1'b0, 16'h0005, 8'h00, cyc_count, rdata);
    check_output("wrap_data", {24'd0, rdata}, 32'h0000_003C);

    // Channel 2 with read and write both high: write goes first, read waits for a fresh request.
    @(negedge clk);
    mem_write_address[2*AB +: AB] = 16'h0030;
    mem_write_data[2*DW +: DW]    = 8'h77;
    mem_read_address[2*AB +: AB]  = 16'h0030;
    mem_write_valid[2] = 1'b1;
    mem_read_valid[2]  = 1'b1;
    got = 1'b0;
    for (int cyc = 0; cyc < 30 && !got; cyc++) begin
      @(negedge clk);
      got = mem_write_ready[2] | mem_read_ready[2];
    end
    check_output("rw_write_first", {31'd0, mem_write_ready[2]}, 32'd1);
    check_output("rw_read_not_first", {31'd0, mem_read_ready[2]}, 32'd0);
    extra_ready = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (mem_read_ready[2] || mem_write_ready[2]) extra_ready++;
    end
    check_output("rw_read_blocked", extra_ready, 32'd0);
    check_output("rw_store_keeps_rdata", {24'd0, mem_read_data[2*DW +: DW]}, 32'h0000_0033);
    mem_write_valid[2] = 1'b0;
    mem_read_valid[2]  = 1'b0;
    repeat (2) @(negedge clk);
    apply_stimulus(2, 1'b0, 16'h0030, 8'h00, cyc_count, rdata);
    check_output("rw_read_data", {24'd0, rdata}, 32'h0000_0077);

    // Reset one cycle after granting a store: the store must be discarded.
    apply_stimulus(0, 1'b1, 16'h0020, 8'h00, cyc_count, rdata);
    @(negedge clk);
    mem_write_address[0*AB +: AB] = 16'h0020;
    mem_write_data[0*DW +: DW]    = 8'hFF;
    mem_write_valid[0] = 1'b1;
    @(negedge clk);
    check_output("rstmid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    mem_write_valid[0] = 1'b0;
    bad_cycles = 0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (mem_read_ready != '0 || mem_write_ready != '0 || busy) bad_cycles++;
    end
    check_output("rstmid_quiet", bad_cycles, 32'd0);
    check_output("rstmid_read_data", mem_read_data, 32'd0);
    reset = 1'b0;
    apply_stimulus(0, 1'b0, 16'h0020, 8'h00, cyc_count, rdata);
    check_output("rstmid_ram_unchanged", {24'd0, rdata}, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
